// File: rtl/axi4l_mst.sv
// axi4l_mst: single-outstanding AXI4-Lite master that turns a command/response
// stream into one AXI4-Lite read or write transaction per accepted command.
module axi4l_mst #(
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] cmd_wstrb,
    input  logic [2:0]                cmd_prot,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [15:0]               rsp_cycles,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [C_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_RSP   = 3'd5
    } state_t;

    state_t state_r, state_s;
    logic   aw_done_r, w_done_r, aw_done_s, w_done_s;
    logic   cmd_ready_s, awvalid_s, wvalid_s, bready_s, arvalid_s, rready_s, rsp_valid_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Handshakes are formed from the registered valid/ready we drive.
    wire aw_hs_s  = m_axi_awvalid & m_axi_awready;
    wire w_hs_s   = m_axi_wvalid & m_axi_wready;
    wire b_hs_s   = m_axi_bvalid & m_axi_bready;
    wire ar_hs_s  = m_axi_arvalid & m_axi_arready;
    wire r_hs_s   = m_axi_rvalid & m_axi_rready;
    wire rsp_hs_s = rsp_valid & rsp_ready;
    wire accept_s = (state_r == ST_IDLE) & cmd_ready & cmd_valid;
    wire busy_s   = (state_r != ST_IDLE) & (state_r != ST_RSP);

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (accept_s) state_s = cmd_write ? ST_WADDR : ST_RADDR;
                      else state_s = ST_IDLE;
            ST_WADDR: if ((aw_done_r | aw_hs_s) & (w_done_r | w_hs_s)) state_s = ST_WRESP;
                      else state_s = ST_WADDR;
            ST_WRESP: if (b_hs_s) state_s = ST_RSP;
                      else state_s = ST_WRESP;
            ST_RADDR: if (ar_hs_s) state_s = ST_RDATA;
                      else state_s = ST_RADDR;
            ST_RDATA: if (r_hs_s) state_s = ST_RSP;
                      else state_s = ST_RDATA;
            ST_RSP:   if (rsp_hs_s) state_s = ST_IDLE;
                      else state_s = ST_RSP;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered control outputs, derived from the next state.
    always_comb begin
        if (state_r == ST_WADDR) begin
            aw_done_s = aw_done_r | aw_hs_s;
            w_done_s  = w_done_r | w_hs_s;
        end else begin
            aw_done_s = 1'b0;
            w_done_s  = 1'b0;
        end
        cmd_ready_s = (state_s == ST_IDLE);
        awvalid_s   = (state_s == ST_WADDR) & ~aw_done_s;
        wvalid_s    = (state_s == ST_WADDR) & ~w_done_s;
        bready_s    = (state_s == ST_WRESP);
        arvalid_s   = (state_s == ST_RADDR);
        rready_s    = (state_s == ST_RDATA);
        rsp_valid_s = (state_s == ST_RSP);
    end

    // Output registers, command capture, response capture and latency count.
    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_done_r     <= 1'b0;
            w_done_r      <= 1'b0;
            cmd_ready     <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awprot  <= 3'd0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_araddr  <= '0;
            m_axi_arprot  <= 3'd0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'd0;
            rsp_cycles    <= 16'd0;
        end else begin
            aw_done_r     <= aw_done_s;
            w_done_r      <= w_done_s;
            cmd_ready     <= cmd_ready_s;
            m_axi_awvalid <= awvalid_s;
            m_axi_wvalid  <= wvalid_s;
            m_axi_bready  <= bready_s;
            m_axi_arvalid <= arvalid_s;
            m_axi_rready  <= rready_s;
            rsp_valid     <= rsp_valid_s;
            if (accept_s) begin
                if (cmd_write) begin
                    m_axi_awaddr <= cmd_addr;
                    m_axi_awprot <= cmd_prot;
                    m_axi_wdata  <= cmd_wdata;
                    m_axi_wstrb  <= cmd_wstrb;
                end else begin
                    m_axi_araddr <= cmd_addr;
                    m_axi_arprot <= cmd_prot;
                end
                rsp_write  <= cmd_write;
                rsp_rdata  <= '0;
                rsp_resp   <= 2'd0;
                rsp_cycles <= 16'd0;
            end else if (busy_s) begin
                // The count includes the B/R handshake cycle itself.
                rsp_cycles <= sat_inc(rsp_cycles);
                if (b_hs_s) begin
                    rsp_resp <= m_axi_bresp;
                end else if (r_hs_s) begin
                    rsp_rdata <= m_axi_rdata;
                    rsp_resp  <= m_axi_rresp;
                end
            end
        end
    end

endmodule
